// File: rtl/adc_seq.sv
// Round-robin ADC acquisition sequencer: walks an enabled-slot table, programs the
// ADC interface per slot, collects a fixed number of samples and buffers them one deep.
//
// state  | meaning
// IDLE   | not acquiring, waiting for start
// SELECT | pick next enabled slot after the pointer
// LOAD   | ldctrl pulse, ctrlword presented
// PWAIT  | programming wait countdown, then wait for mbusy low
// ACQ    | enable high, counting samples
// DRAIN  | enable low, waiting for mbusy low
module adc_seq #(
  parameter int NSLOT = 4,
  parameter int PROG_WAIT = 64,
  localparam int IW = (NSLOT > 1) ? $clog2(NSLOT) : 1
) (
  input  logic          clk,
  input  logic          arstn,
  input  logic          start,
  input  logic          stop,
  input  logic          cfg_wr,
  input  logic [IW-1:0] cfg_idx,
  input  logic [9:0]    cfg_word,
  input  logic [15:0]   cfg_nsamp,
  input  logic          cfg_en,
  output logic [9:0]    ctrlword,
  output logic          ldctrl,
  output logic          enable,
  input  logic          mbusy,
  input  logic [31:0]   douta,
  input  logic          valida,
  output logic [31:0]   sample_data,
  output logic [IW-1:0] sample_slot,
  output logic          sample_valid,
  input  logic          sample_ready,
  output logic          running,
  output logic          overflow,
  input  logic          clr_ovf
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_PWAIT  = 3'd3;
  localparam logic [2:0] S_ACQ    = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;
  localparam int WW = (PROG_WAIT > 1) ? $clog2(PROG_WAIT) : 1;

  logic [2:0]       state_q, state_d;
  logic [9:0]       tbl_word_q [NSLOT];
  logic [9:0]       tbl_word_d [NSLOT];
  logic [15:0]      tbl_nsamp_q [NSLOT];
  logic [15:0]      tbl_nsamp_d [NSLOT];
  logic [NSLOT-1:0] tbl_en_q, tbl_en_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic             stop_pend_q, stop_pend_d;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic [15:0]      scnt_q, scnt_d;
  logic [15:0]      nsamp_q, nsamp_d;
  logic [9:0]       ctrlword_q, ctrlword_d;
  logic [31:0]      sdata_q, sdata_d;
  logic [IW-1:0]    sslot_q, sslot_d;
  logic             svalid_q, svalid_d;
  logic             ovf_q, ovf_d;

  logic             found;
  logic [IW-1:0]    nxt_slot;
  logic [IW-1:0]    cand;
  logic             pend_now;
  logic [15:0]      last_cnt;
  logic             take;

  always_comb begin
    tbl_word_d  = tbl_word_q;
    tbl_nsamp_d = tbl_nsamp_q;
    tbl_en_d    = tbl_en_q;
    if (cfg_wr) begin
      tbl_word_d[cfg_idx]  = cfg_word;
      tbl_nsamp_d[cfg_idx] = cfg_nsamp;
      tbl_en_d[cfg_idx]    = cfg_en;
    end
  end

  // Scan downward so the nearest enabled slot after the pointer wins; k=NSLOT is the pointer itself.
  always_comb begin
    found    = 1'b0;
    nxt_slot = ptr_q;
    cand     = '0;
    for (int k = NSLOT; k >= 1; k--) begin
      cand = ptr_q + IW'(k);
      if (tbl_en_q[cand]) begin
        found    = 1'b1;
        nxt_slot = cand;
      end
    end
  end

  assign pend_now = stop_pend_q | (stop & (state_q != S_IDLE));
  assign last_cnt = (nsamp_q == 16'd0) ? 16'd0 : nsamp_q - 16'd1;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    ctrlword_d = ctrlword_q;
    wcnt_d     = wcnt_q;
    scnt_d     = scnt_q;
    nsamp_d    = nsamp_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_SELECT;
      S_SELECT: begin
        if (pend_now || !found) begin
          state_d = S_IDLE;
        end else begin
          ptr_d      = nxt_slot;
          ctrlword_d = tbl_word_q[nxt_slot];
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        wcnt_d  = WW'(PROG_WAIT - 1);
        state_d = S_PWAIT;
      end
      S_PWAIT: begin
        if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - 1'b1;
        end else if (pend_now) begin
          state_d = S_IDLE;
        end else if (!mbusy) begin
          scnt_d  = '0;
          nsamp_d = tbl_nsamp_q[ptr_q];
          state_d = S_ACQ;
        end
      end
      S_ACQ: begin
        if (stop) begin
          state_d = S_DRAIN;
        end else if (valida) begin
          if (scnt_q == last_cnt) state_d = S_DRAIN;
          else scnt_d = scnt_q + 16'd1;
        end
      end
      S_DRAIN: if (!mbusy) state_d = S_SELECT;
      default: state_d = S_IDLE;
    endcase
    stop_pend_d = (state_d == S_IDLE) ? 1'b0 : pend_now;
  end

  // A drop on a full, unaccepted buffer keeps the old sample; a set beats a clear.
  always_comb begin
    take     = valida && (state_q == S_ACQ || state_q == S_DRAIN);
    sdata_d  = sdata_q;
    sslot_d  = sslot_q;
    svalid_d = svalid_q;
    ovf_d    = ovf_q & ~clr_ovf;
    if (take) begin
      if (!svalid_q || sample_ready) begin
        sdata_d  = douta;
        sslot_d  = ptr_q;
        svalid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (sample_ready) begin
      svalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < NSLOT; i++) begin
        tbl_word_q[i]  <= '0;
        tbl_nsamp_q[i] <= '0;
      end
      tbl_en_q    <= '0;
      ptr_q       <= IW'(NSLOT - 1);
      stop_pend_q <= 1'b0;
      wcnt_q      <= '0;
      scnt_q      <= '0;
      nsamp_q     <= '0;
      ctrlword_q  <= '0;
      sdata_q     <= '0;
      sslot_q     <= '0;
      svalid_q    <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tbl_word_q  <= tbl_word_d;
      tbl_nsamp_q <= tbl_nsamp_d;
      tbl_en_q    <= tbl_en_d;
      ptr_q       <= ptr_d;
      stop_pend_q <= stop_pend_d;
      wcnt_q      <= wcnt_d;
      scnt_q      <= scnt_d;
      nsamp_q     <= nsamp_d;
      ctrlword_q  <= ctrlword_d;
      sdata_q     <= sdata_d;
      sslot_q     <= sslot_d;
      svalid_q    <= svalid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign ctrlword     = ctrlword_q;
  assign ldctrl       = (state_q == S_LOAD);
  assign enable       = (state_q == S_ACQ);
  assign running      = (state_q != S_IDLE);
  assign sample_data  = sdata_q;
  assign sample_slot  = sslot_q;
  assign sample_valid = svalid_q;
  assign overflow     = ovf_q;

endmodule

// File: doc/adc_seq.md
ADC_SEQ -- requirements
Module: adc_seq

Interface
REQ-001 SHALL have parameter NSLOT, default 4: number of configuration slots (power of 2, 2..8).
REQ-002 SHALL have parameter PROG_WAIT, default 64: minimum clk cycles from ldctrl pulse to first enable.
REQ-003 SHALL have ports (clock and reset first), IW = log2(NSLOT):
clk  in  1  single system clock, all logic on rising edge
arstn  in  1  asynchronous active-low reset
start  in  1  pulse, begin round-robin acquisition
stop  in  1  pulse, end acquisition gracefully
cfg_wr  in  1  write strobe for slot table
cfg_idx  in  IW  slot index to write
cfg_word  in  10  ADC control word for slot
cfg_nsamp  in  16  samples to collect per slot visit
cfg_en  in  1  slot enable bit
ctrlword  out  10  control word to ADC interface
ldctrl  out  1  one-cycle load-control pulse to ADC interface
enable  out  1  sampling enable to ADC interface
mbusy  in  1  ADC interface busy (programming/readout in progress)
douta  in  32  sample from ADC interface
valida  in  1  one-cycle sample strobe
sample_data  out  32  buffered sample
sample_slot  out  IW  slot that produced sample_data
sample_valid  out  1  buffer holds a sample
sample_ready  in  1  downstream accepts when high with sample_valid
running  out  1  high in any state except IDLE
overflow  out  1  sticky sample-drop flag
clr_ovf  in  1  clears overflow

Function
REQ-004 SHALL keep a slot table of NSLOT entries {word[9:0], nsamp[15:0], en}; cfg_wr writes entry cfg_idx at the next edge in every state.
REQ-005 SHALL implement states IDLE, SELECT, LOAD, PWAIT, ACQ, DRAIN.
REQ-006 IDLE: start -> SELECT; start in any other state SHALL be ignored.
REQ-007 SELECT (one cycle): pick the first enabled slot after current pointer, wrapping modulo NSLOT (current slot itself checked last); found -> pointer=slot, LOAD; none enabled or stop pending -> IDLE.
REQ-008 LOAD (one cycle): ldctrl=1, ctrlword registered from table word; ctrlword SHALL hold until next LOAD; wait counter=PROG_WAIT-1; -> PWAIT.
REQ-009 PWAIT: decrement counter; when counter==0 and mbusy==0 -> ACQ with enable=1, sample count=0; if stop pending -> IDLE instead.
REQ-010 ACQ: each valida increments sample count; on valida with count==nsamp-1 (nsamp=0 treated as 1) enable SHALL drop at the next edge and state -> DRAIN.
REQ-011 stop in ACQ SHALL drop enable at the next edge and -> DRAIN; stop in LOAD/PWAIT/DRAIN SHALL set stop-pending, never abort programming.
REQ-012 DRAIN: wait mbusy==0, then -> SELECT (which goes to IDLE if stop pending); stop-pending clears on IDLE entry.
REQ-013 valida in ACQ or DRAIN SHALL be buffered with current pointer as tag; valida in other states SHALL be ignored; DRAIN samples do not count.
REQ-014 Output buffer is one entry: load when empty or sample_ready high in same cycle (simultaneous accept and refill allowed); valida while full and not ready drops new sample, keeps old, sets overflow.
REQ-015 sample_valid SHALL hold data/tag stable until accepted.
REQ-016 overflow set and clr_ovf same cycle: set wins.
REQ-017 Table write to the active slot SHALL take effect on its next visit only; nsamp captured at ACQ entry.

Reset
REQ-018 arstn low SHALL immediately force IDLE; ctrlword, ldctrl, enable, sample_data, sample_slot, sample_valid, running, overflow = 0; table cleared; pointer = NSLOT-1 so first SELECT picks slot 0.
REQ-019 Reset mid-ACQ SHALL drop enable asynchronously; no sample emitted after arstn asserts.

Verification
REQ-020 Slots 0,2 enabled (word 0x155 nsamp 3, word 0x0AA nsamp 2), start -> ldctrl with 0x155, enable >= PROG_WAIT cycles later, 3 samples tagged 0, then 0x0AA, 2 samples tagged 2, then slot 0 again.
REQ-021 No slots enabled, start -> one SELECT cycle, back to IDLE, ldctrl never asserts.
REQ-022 sample_ready held low, 2 valida in ACQ -> first sample held, overflow=1; clr_ovf with simultaneous drop -> overflow stays 1.
REQ-023 stop during PWAIT -> no enable pulse, IDLE after counter expiry, running=0.
REQ-024 stop in ACQ after 1 of 5 samples, mbusy high 10 cycles -> enable drops next edge, IDLE after mbusy falls, in-flight valida still delivered.
REQ-025 arstn pulse during ACQ -> all outputs 0 asynchronously; subsequent start selects slot 0 after reprogramming table.
